// File: rtl/pipe_dmem.sv
`default_nettype none
// ============================================================================
// Module      : pipe_dmem
// Description : Single-port 32-bit data memory with byte/half/word accesses,
//               one-cycle registered loads and optional zero-fill after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_dmem #(
    parameter int AW             = 5,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] addr,
    input  logic [31:0] datain,
    output logic        ready,
    output logic [31:0] dataout,
    output logic        rvalid,
    output logic        fault
);

    localparam int c_DEPTH = 2 ** AW;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_clr_cnt;
    logic [31:0]   r_mem [c_DEPTH];

    logic          r_rvalid;
    logic          r_fault;
    logic [31:0]   r_dataout;

    logic [AW-1:0] w_idx;
    logic [1:0]    w_lane;
    logic          w_ready;
    logic          w_accept;
    logic          w_legal;
    logic          w_store;
    logic          w_load;
    logic          w_bad_acc;
    logic          w_clr_we;
    logic          w_clr_done;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_rword;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_ldval;
    logic          w_unused_addr;

    assign w_idx         = addr[AW+1:2];
    assign w_lane        = addr[1:0];
    assign w_unused_addr = ^addr[31:AW+2];

    // ------------------------------------------------------------------
    // Control FSM: INIT walks the clear counter over every word, RUN serves
    // ------------------------------------------------------------------
    assign w_clr_done = (r_clr_cnt == AW'(c_DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (w_clr_done) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_cnt <= '0;
        end else if (r_state == ST_INIT) begin
            r_clr_cnt <= r_clr_cnt + AW'(1);
        end
    end

    // Without zero-fill the block stays available through reset
    assign w_ready   = (r_state == ST_RUN) && !(CLEAR_ON_RESET && rst);
    assign w_accept  = req && w_ready && !rst;
    assign w_clr_we  = (r_state == ST_INIT) && !rst;

    // ------------------------------------------------------------------
    // Access decode: legality, byte enables and replicated store data
    // ------------------------------------------------------------------
    always_comb begin
        w_legal = 1'b0;
        w_be    = 4'b0000;
        w_wdata = datain;
        case (size)
            2'b00: begin
                w_legal = 1'b1;
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{datain[7:0]}};
            end
            2'b01: begin
                w_legal = ~addr[0];
                w_be    = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{datain[15:0]}};
            end
            2'b10: begin
                w_legal = (w_lane == 2'b00);
                w_be    = 4'b1111;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    assign w_store   = w_accept &&  we && w_legal;
    assign w_load    = w_accept && !we && w_legal;
    assign w_bad_acc = w_accept && !w_legal;

    // Storage is never reset so CLEAR_ON_RESET=0 keeps contents across rst
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_store) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Load extraction and result registers
    // ------------------------------------------------------------------
    assign w_rword = r_mem[w_idx];
    assign w_half  = addr[1] ? w_rword[31:16] : w_rword[15:0];

    always_comb begin
        case (w_lane)
            2'b00:   w_byte = w_rword[7:0];
            2'b01:   w_byte = w_rword[15:8];
            2'b10:   w_byte = w_rword[23:16];
            default: w_byte = w_rword[31:24];
        endcase
    end

    always_comb begin
        case (size)
            2'b00:   w_ldval = {{24{~unsigned_ld & w_byte[7]}}, w_byte};
            2'b01:   w_ldval = {{16{~unsigned_ld & w_half[15]}}, w_half};
            default: w_ldval = w_rword;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid  <= 1'b0;
            r_fault   <= 1'b0;
            r_dataout <= '0;
        end else begin
            r_rvalid <= w_load;
            r_fault  <= w_bad_acc;
            if (w_load) begin
                r_dataout <= w_ldval;
            end
        end
    end

    // Outputs are masked by rst so a result in flight is squashed at once
    assign ready   = w_ready;
    assign rvalid  = r_rvalid & ~rst;
    assign fault   = r_fault & ~rst;
    assign dataout = rst ? 32'd0 : r_dataout;

endmodule
`default_nettype wire

// File: tb/tb_pipe_dmem.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_dmem
// Description : Directed scoreboard bench for pipe_dmem (zero-fill and
//               contents-preserving instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_dmem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_nc = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b10;
    logic        unsigned_ld = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] datain = '0;

    logic        ready, rvalid, fault;
    logic [31:0] dataout;
    logic        ready_nc, rvalid_nc, fault_nc;
    logic [31:0] dataout_nc;

    pipe_dmem #(.AW(5), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size),
        .unsigned_ld(unsigned_ld), .addr(addr), .datain(datain),
        .ready(ready), .dataout(dataout), .rvalid(rvalid), .fault(fault)
    );

    pipe_dmem #(.AW(5), .CLEAR_ON_RESET(1'b0)) dut_nc (
        .clk(clk), .rst(rst_nc), .req(req), .we(we), .size(size),
        .unsigned_ld(unsigned_ld), .addr(addr), .datain(datain),
        .ready(ready_nc), .dataout(dataout_nc), .rvalid(rvalid_nc), .fault(fault_nc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        flt;
        int          due;
        int          id;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_id = 0;
    logic [31:0] last_out = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every cycle either a due entry or a quiet output
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            n_cmp++;
            assert (rvalid === !e.flt && fault === e.flt && dataout === e.data)
            else begin
                n_err++;
                $error("FAIL %s#%0d: rvalid=%b fault=%b dataout=%h, expected rvalid=%b fault=%b dataout=%h",
                       e.flt ? "fault" : "load", e.id, rvalid, fault, dataout, !e.flt, e.flt, e.data);
            end
        end else begin
            n_cmp++;
            assert (rvalid === 1'b0 && fault === 1'b0 && (!rst || dataout === 32'd0))
            else begin
                n_err++;
                $error("FAIL quiet@%0d: rvalid=%b fault=%b dataout=%h, expected rvalid=0 fault=0 (dataout=0 in rst)",
                       cyc, rvalid, fault, dataout);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic legal_f(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b00) || (sz == 2'b01 && a[0] == 1'b0) || (sz == 2'b10 && a[1:0] == 2'b00);
    endfunction

    task automatic drive(input logic rq, input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        req = rq; we = w; size = sz; unsigned_ld = u; addr = a; datain = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic push(input logic [31:0] d, input logic f);
        exp_t e;
        e.data = d; e.flt = f; e.due = cyc + 1; e.id = n_id++;
        sb_q.push_back(e);
    endtask

    task automatic ld(input logic [1:0] sz, input logic u, input logic [31:0] a, input logic [31:0] exp);
        drive(1'b1, 1'b0, sz, u, a, 32'd0);
        if (legal_f(sz, a)) begin
            push(exp, 1'b0);
            last_out = exp;
        end else begin
            push(last_out, 1'b1);
        end
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, 1'b1, sz, 1'b0, a, d);
        if (!legal_f(sz, a)) push(last_out, 1'b1);
    endtask

    // Releases rst and counts the cycles ready stays low afterwards
    task automatic count_init(input string tag);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        rst = 1'b0; req = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (ready) break;
            n++;
        end
        chk(tag, n, 32);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        idle(2);
        @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_dataout", dataout, 32'd0);
        chk("rst_nc_ready", {31'd0, ready_nc}, 32'd1);
        @(posedge clk);
        #1;
        rst_nc = 1'b0;
        count_init("init_len");

        // Zero-fill covers every word
        for (int i = 0; i < 32; i++) ld(2'b10, 1'b0, 32'(i * 4), 32'h0000_0000);

        // Byte loads, signed and unsigned
        st(2'b10, 32'h10, 32'h80FF_7F01);
        ld(2'b00, 1'b0, 32'h10, 32'h0000_0001);
        ld(2'b00, 1'b0, 32'h11, 32'h0000_007F);
        ld(2'b00, 1'b0, 32'h12, 32'hFFFF_FFFF);
        ld(2'b00, 1'b0, 32'h13, 32'hFFFF_FF80);
        ld(2'b00, 1'b1, 32'h13, 32'h0000_0080);

        // Half store over a word, lane merges
        st(2'b10, 32'h20, 32'h1122_3344);
        st(2'b01, 32'h22, 32'hAAAA_BEEF);
        ld(2'b10, 1'b0, 32'h20, 32'hBEEF_3344);
        ld(2'b01, 1'b0, 32'h22, 32'hFFFF_BEEF);
        ld(2'b01, 1'b1, 32'h22, 32'h0000_BEEF);
        ld(2'b01, 1'b0, 32'h20, 32'h0000_3344);
        st(2'b00, 32'h21, 32'hFFFF_FF5A);
        ld(2'b10, 1'b0, 32'h20, 32'hBEEF_5A44);
        ld(2'b00, 1'b0, 32'h23, 32'hFFFF_FFBE);

        // Misaligned and reserved accesses
        st(2'b10, 32'h06, 32'hDEAD_BEEF);
        ld(2'b10, 1'b0, 32'h04, 32'h0000_0000);
        st(2'b11, 32'h04, 32'hDEAD_BEEF);
        ld(2'b10, 1'b0, 32'h04, 32'h0000_0000);
        st(2'b01, 32'h05, 32'h0000_BEEF);
        ld(2'b10, 1'b0, 32'h04, 32'h0000_0000);
        ld(2'b10, 1'b0, 32'h22, 32'h0);
        ld(2'b01, 1'b0, 32'h21, 32'h0);
        ld(2'b11, 1'b0, 32'h20, 32'h0);
        ld(2'b00, 1'b0, 32'h07, 32'h0000_0000);

        // Store then immediate load, continuous loads
        st(2'b10, 32'h08, 32'h1234_5678);
        ld(2'b10, 1'b0, 32'h08, 32'h1234_5678);
        ld(2'b10, 1'b0, 32'h08, 32'h1234_5678);
        ld(2'b10, 1'b0, 32'h08, 32'h1234_5678);
        ld(2'b01, 1'b1, 32'h0A, 32'h0000_1234);
        ld(2'b00, 1'b1, 32'h08, 32'h0000_0078);
        ld(2'b00, 1'b0, 32'h0B, 32'h0000_0012);

        // Address aliasing above the word index
        st(2'b10, 32'h8C, 32'hA5A5_0F0F);
        ld(2'b10, 1'b0, 32'h0C, 32'hA5A5_0F0F);
        ld(2'b10, 1'b0, 32'hFFFF_FF8C, 32'hA5A5_0F0F);
        idle(2);

        // rst in the cycle after a load acceptance squashes the result
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h08, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1; req = 1'b0;
        last_out = '0;
        @(negedge clk);
        chk("squash_rvalid", {31'd0, rvalid}, 32'd0);
        chk("squash_dataout", dataout, 32'd0);
        idle(1);

        // rst mid-INIT restarts the clear walk
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(10);
        @(negedge clk);
        chk("mid_init_ready", {31'd0, ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        count_init("init_restart_len");
        ld(2'b10, 1'b0, 32'h10, 32'h0000_0000);
        ld(2'b10, 1'b0, 32'h08, 32'h0000_0000);

        // Contents survive reset without zero-fill
        st(2'b10, 32'h14, 32'hCAFE_F00D);
        @(posedge clk);
        #1;
        rst_nc = 1'b1; req = 1'b0;
        @(negedge clk);
        chk("nc_rst_ready", {31'd0, ready_nc}, 32'd1);
        chk("nc_rst_dataout", dataout_nc, 32'd0);
        @(posedge clk);
        #1;
        rst_nc = 1'b0;
        @(negedge clk);
        chk("nc_post_rst_rvalid", {31'd0, rvalid_nc}, 32'd0);
        ld(2'b10, 1'b0, 32'h14, 32'hCAFE_F00D);
        idle(1);
        @(negedge clk);
        chk("nc_keep_rvalid", {31'd0, rvalid_nc}, 32'd1);
        chk("nc_keep_word", dataout_nc, 32'hCAFE_F00D);
        ld(2'b00, 1'b0, 32'h17, 32'hFFFF_FFCA);
        idle(1);
        @(negedge clk);
        chk("nc_keep_byte", dataout_nc, 32'hFFFF_FFCA);
        idle(3);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
